load_store_unit: RTL and testbench

//   CPU-side initiator for the word-only data memory (dm). Accepts one load/store request
//   at a time from the MEM stage. Issues word reads/writes to dm; sub-word stores (sb/sh)
//   run as read-modify-write. Returns extended load data with a one-cycle response pulse.

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit_byte_lane.sv | 59 +++++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, the zero word,
// the request control bundle and the alignment predicate used by the optional
// address checker (LSU_ALIGN_CHECK_EN).
package load_store_unit_pkg;

  // Access sizes as driven on req_size.
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  // FSM state encodings.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  // Request attributes latched at accept.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       isSigned;
  } reqCtrl_t;

  // Half needs bit 0 clear, word needs both low bits clear; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (size == MEM_H) begin
      bad = offset[0];
    end else if (size == MEM_W) begin
      bad = (offset != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane logic for the load/store unit: merges store data into a
// fetched dm word (sb/sh read-modify-write, sw passthrough) and selects and extends
// the addressed byte/half/word for loads. Little-endian: byte k = bits [8k+7:8k].
module load_store_unit_byte_lane
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [31:0] wdata,
  output logic [31:0] mergedWord,
  output logic [31:0] loadData
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Store merge: replace the addressed lane of the fetched word.
  always_comb begin
    mergedWord = word;
    case (size)
      MEM_B: begin
        unique case (offset)
          2'd0: mergedWord[7:0]   = wdata[7:0];
          2'd1: mergedWord[15:8]  = wdata[7:0];
          2'd2: mergedWord[23:16] = wdata[7:0];
          2'd3: mergedWord[31:24] = wdata[7:0];
        endcase
      end
      MEM_H: begin
        if (offset[1]) begin
          mergedWord[31:16] = wdata[15:0];
        end else begin
          mergedWord[15:0] = wdata[15:0];
        end
      end
      default: mergedWord = wdata;
    endcase
  end

  // Load select and extend; the half lane uses only offset[1].
  always_comb begin
    selByte = word[7:0];
    unique case (offset)
      2'd0: selByte = word[7:0];
      2'd1: selByte = word[15:8];
      2'd2: selByte = word[23:16];
      2'd3: selByte = word[31:24];
    endcase
    selHalf = offset[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_B:   loadData = {{24{isSigned & selByte[7]}}, selByte};
      MEM_H:   loadData = {{16{isSigned & selHalf[15]}}, selHalf};
      default: loadData = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for the word-only data memory.
// Loads: IDLE->RD->RESP. sw: IDLE->WR->RESP. sb/sh: IDLE->RD->WR->RESP (RMW).
// Optional feature macro LSU_ALIGN_CHECK_EN adds the addr_err port and rejects
// misaligned or out-of-range requests with a direct IDLE->RESP error response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] dm_raddr,
  output logic [ADDR_W-1:0] dm_waddr,
  output logic [31:0]       dm_wdata,
  output logic [31:0]       dm_pc,
  output logic              dm_ren,
  output logic              dm_wen,
  input  logic [31:0]       dm_rdata
`ifdef LSU_ALIGN_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  logic [1:0]        stateQ, stateD;
  logic [ADDR_W-1:0] addrQ;
  reqCtrl_t          ctrlQ;
  logic [31:0]       wdataQ;
  logic [31:0]       pcQ;
  logic [31:0]       dataQ;
  logic              accept;
  logic              reqErr;
  logic              errFlag;
  logic [ADDR_W-1:0] wordAddr;
  logic [31:0]       mergedWord;
  logic [31:0]       loadData;

  assign accept   = req_valid & req_ready;
  assign wordAddr = {addrQ[ADDR_W-1:2], 2'b00};

`ifdef LSU_ALIGN_CHECK_EN
  logic errQ;

  // Bad alignment for the size, or a byte address beyond the end of dm.
  assign reqErr = misaligned(req_size, req_addr[1:0]) ||
                  (64'(req_addr) >= 64'(DM_WORDS) * 64'd4);
  assign errFlag = errQ;

  // Error flag is held for the whole transaction and cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      errQ <= 1'b0;
    end else if (accept) begin
      errQ <= reqErr;
    end
  end

  assign addr_err = resp_valid & errQ;
`else
  assign reqErr  = 1'b0;
  assign errFlag = 1'b0;
`endif

  // State, request latch at accept, and dm read-data capture in RD.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= IDLE;
      addrQ  <= '0;
      ctrlQ  <= '0;
      wdataQ <= ZERO;
      pcQ    <= ZERO;
      dataQ  <= ZERO;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        addrQ  <= req_addr;
        ctrlQ  <= '{we: req_we, size: req_size, isSigned: req_signed};
        wdataQ <= req_wdata;
        pcQ    <= req_pc;
      end
      if (stateQ == RD) begin
        dataQ <= dm_rdata;
      end
    end
  end

  // Next-state: only sub-word stores need the read before the write.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (accept) begin
          if (reqErr) begin
            stateD = RESP;
          end else if (!req_we || req_size == MEM_B || req_size == MEM_H) begin
            stateD = RD;
          end else begin
            stateD = WR;
          end
        end
      end
      RD:      stateD = ctrlQ.we ? WR : RESP;
      WR:      stateD = RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  load_store_unit_byte_lane u_byte_lane (
    .word       (dataQ),
    .offset     (addrQ[1:0]),
    .size       (ctrlQ.size),
    .isSigned   (ctrlQ.isSigned),
    .wdata      (wdataQ),
    .mergedWord (mergedWord),
    .loadData   (loadData)
  );

  // Outputs decoded from state; dm buses are held at zero outside their active state.
  always_comb begin
    req_ready  = (stateQ == IDLE);
    resp_valid = (stateQ == RESP);
    dm_ren     = (stateQ == RD);
    dm_wen     = (stateQ == WR);
    dm_raddr   = dm_ren ? wordAddr : '0;
    dm_waddr   = dm_wen ? wordAddr : '0;
    dm_wdata   = dm_wen ? mergedWord : ZERO;
    dm_pc      = pcQ;
    resp_rdata = (resp_valid && !ctrlQ.we && !errFlag) ? loadData : ZERO;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory on the dm
// side and a scoreboard of expected responses. Define LSU_ALIGN_CHECK_EN for both the
// RTL and this file to exercise the address-error path.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 32;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we, req_signed;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata, req_pc;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] dm_raddr, dm_waddr;
  logic [31:0]       dm_wdata, dm_pc, dm_rdata;
  logic              dm_ren, dm_wen;
`ifdef LSU_ALIGN_CHECK_EN
  logic              addr_err;
`endif

  load_store_unit #(.ADDR_W(ADDR_W), .DM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .dm_raddr   (dm_raddr),
    .dm_waddr   (dm_waddr),
    .dm_wdata   (dm_wdata),
    .dm_pc      (dm_pc),
    .dm_ren     (dm_ren),
    .dm_wen     (dm_wen),
    .dm_rdata   (dm_rdata)
`ifdef LSU_ALIGN_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural dm: combinational read, write on the clock edge.
  logic [31:0] mem    [64];
  logic [31:0] expMem [64];
  assign dm_rdata = mem[dm_raddr[7:2]];
  always @(posedge clk) begin
    if (dm_wen) mem[dm_waddr[7:2]] <= dm_wdata;
  end

  typedef struct {
    logic [31:0] rdata;
    int          latency;
    logic        isStore;
    logic        rmw;
    logic        err;
    logic [31:0] wword;
    logic [31:0] waddr;
    logic [31:0] pc;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input logic sgn);
    logic [31:0] s;
    if (sz == SZ_B) begin
      s = (w >> (8 * off)) & 32'h0000_00FF;
      if (sgn && s[7]) s = s | 32'hFFFF_FF00;
    end else if (sz == SZ_H) begin
      s = (w >> (off[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (sgn && s[15]) s = s | 32'hFFFF_0000;
    end else begin
      s = w;
    end
    return s;
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    if (sz == SZ_B) begin
      sh = 8 * off;
      mask = 32'h0000_00FF << sh;
      return (w & ~mask) | ((d & 32'h0000_00FF) << sh);
    end else if (sz == SZ_H) begin
      sh = off[1] ? 16 : 0;
      mask = 32'h0000_FFFF << sh;
      return (w & ~mask) | ((d & 32'h0000_FFFF) << sh);
    end
    return d;
  endfunction

  // Issue one request, push its expectation, then watch the DUT until the response.
  task automatic doReq(input string tag, input logic we, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                       input bit holdValid, input bit expectNoWait);
    exp_t        e, got;
    int          idx, waits, wenCnt, renCnt, wenAt, busyReady;
    logic [31:0] wenData, wenAddr;
    bit          seen;
    idx = int'(addr[7:2]);
`ifdef LSU_ALIGN_CHECK_EN
    e.err = (sz == SZ_H && addr[0]) || (sz == SZ_W && addr[1:0] != 2'b00) ||
            (addr >= 32'd4096);
`else
    e.err = 1'b0;
`endif
    e.isStore = we;
    e.rmw     = we && (sz == SZ_B || sz == SZ_H) && !e.err;
    e.rdata   = (we || e.err) ? 32'h0 : refLoad(expMem[idx], addr[1:0], sz, sgn);
    e.latency = e.err ? 1 : (e.rmw ? 3 : 2);
    e.wword   = refMerge(expMem[idx], addr[1:0], sz, wd);
    e.waddr   = {addr[31:2], 2'b00};
    e.pc      = 32'h0000_4000 ^ addr;
    if (we && !e.err) expMem[idx] = e.wword;
    expQ.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_pc = e.pc;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (expectNoWait) checkEq({tag, " accept wait"}, waits, 0);
    @(posedge clk);

    wenCnt = 0; renCnt = 0; wenAt = -1; busyReady = 0; seen = 1'b0;
    wenData = 32'h0; wenAddr = 32'h0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (!holdValid) req_valid = 1'b0;
      if (req_ready) busyReady++;
      if (dm_ren) renCnt++;
      if (dm_wen) begin
        wenCnt++; wenAt = k; wenData = dm_wdata; wenAddr = dm_waddr;
      end
      if (resp_valid) begin
        seen = 1'b1;
        got = expQ.pop_front();
        checkEq({tag, " latency"}, k, got.latency);
        checkEq({tag, " rdata"}, resp_rdata, got.rdata);
        checkEq({tag, " dm_pc"}, dm_pc, got.pc);
`ifdef LSU_ALIGN_CHECK_EN
        checkEq({tag, " addr_err"}, addr_err, got.err);
`endif
        checkEq({tag, " wen count"}, wenCnt, (got.isStore && !got.err) ? 1 : 0);
        checkEq({tag, " ren count"}, renCnt, ((!got.isStore || got.rmw) && !got.err) ? 1 : 0);
        checkEq({tag, " ready while busy"}, busyReady, 0);
        if (got.isStore && !got.err) begin
          checkEq({tag, " wen cycle"}, wenAt, got.latency - 1);
          checkEq({tag, " dm_wdata"}, wenData, got.wword);
          checkEq({tag, " dm_waddr"}, wenAddr, got.waddr);
        end
      end
    end
    if (!seen) begin
      checkEq({tag, " response timeout"}, 32'd0, 32'd1);
      void'(expQ.pop_front());
    end
  endtask

  initial begin
    int wenSeen;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hC0DE_0000 + i;
      expMem[i] = 32'hC0DE_0000 + i;
    end
    mem[4]    = 32'h8899_AABB;
    expMem[4] = 32'h8899_AABB;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkEq("reset req_ready", req_ready, 1);
    checkEq("reset resp_valid", resp_valid, 0);
    checkEq("reset dm_ren", dm_ren, 0);
    checkEq("reset dm_wen", dm_wen, 0);
    checkEq("reset resp_rdata", resp_rdata, 0);
    checkEq("reset dm_raddr", dm_raddr, 0);
    checkEq("reset dm_waddr", dm_waddr, 0);
    checkEq("reset dm_wdata", dm_wdata, 0);
    checkEq("reset dm_pc", dm_pc, 0);

    doReq("lb 0x11",  1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
    doReq("lhu 0x12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 1'b0, 1'b0);
    doReq("lh 0x12",  1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 1'b0, 1'b0);
    doReq("sb 0x13",  1'b1, SZ_B, 1'b0, 32'h13, 32'h0000_005C, 1'b0, 1'b0);
    doReq("sw 0x20",  1'b1, SZ_W, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 1'b0);
    doReq("lw 0x20",  1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    doReq("lbu 0x13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
    doReq("lh 0x10",  1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    doReq("sh 0x16",  1'b1, SZ_H, 1'b0, 32'h16, 32'hFFFF_BEEF, 1'b0, 1'b0);
    doReq("lw 0x14",  1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0);
`ifndef LSU_ALIGN_CHECK_EN
    doReq("lw 0x22 unaligned", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 1'b0, 1'b0);
    doReq("sh 0x11 unaligned", 1'b1, SZ_H, 1'b0, 32'h11, 32'h0000_7E7E, 1'b0, 1'b0);
    doReq("lw 0x10 after sh",  1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
`else
    doReq("lw 0x22 err",    1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 1'b0, 1'b0);
    doReq("lh 0x11 err",    1'b0, SZ_H, 1'b1, 32'h11, 32'h0, 1'b0, 1'b0);
    doReq("sw 0x1000 err",  1'b1, SZ_W, 1'b0, 32'h1000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    doReq("sb 0x17 ok",     1'b1, SZ_B, 1'b0, 32'h17, 32'h0000_00A5, 1'b0, 1'b0);
`endif

    // Back-to-back: req_valid stays high; the second request is taken right after RESP.
    doReq("b2b lw 0x20",  1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    doReq("b2b lb 0x23",  1'b0, SZ_B, 1'b1, 32'h23, 32'h0, 1'b0, 1'b1);

    // Reset while an sb sits in RD: the write must never happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0077; req_pc = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkEq("rst-mid dm_ren in RD", dm_ren, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkEq("rst-mid req_ready", req_ready, 1);
    wenSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dm_wen || resp_valid) wenSeen++;
    end
    checkEq("rst-mid no wen/resp", wenSeen, 0);

    for (int i = 4; i <= 8; i++) begin
      checkEq($sformatf("mem word %0d", i), mem[i], expMem[i]);
    end
    checkEq("scoreboard empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
